// File: rtl/cnt_req_pkg.sv
// Purpose: shared types and helpers for the counter-cell pulse requester.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
package cnt_req_pkg;

    // Per-channel handshake state.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2
    } chan_st_t;

    // Direction of the outstanding request: plus drives CxxP, minus drives CxxM.
    typedef enum logic {
        DIR_P = 1'b0,
        DIR_M = 1'b1
    } dir_t;

    // Gap counter width; it covers the legal gap range 1..7.
    localparam int GAP_CNT_W = 3;

    // Largest backlog magnitude a signed accumulator of acc_w bits may hold.
    // The most negative two's-complement code is never used, so the range is symmetric.
    function automatic int sat_max(input int acc_w);
        return (1 << (acc_w - 1)) - 1;
    endfunction

endpackage

// File: rtl/cnt_pulse_requester_if.sv
// Purpose: pulse inputs, acknowledges and request/status outputs of the requester.
// Latency: n/a (wiring only).
// Backpressure: ack_r is the only return path; requests are held until it arrives.
interface cnt_pulse_requester_if #(
    parameter int NCH = 4
);
    logic [NCH-1:0] pls_up;
    logic [NCH-1:0] pls_dn;
    logic [NCH-1:0] ack_r;
    logic           flush;
    logic           ovf_clr;
    logic [NCH-1:0] req_p;
    logic [NCH-1:0] req_m;
    logic [NCH-1:0] backlog_nz;
    logic [NCH-1:0] ovf;

    // Pulse sources, counter cell and control side.
    modport master (
        output pls_up, pls_dn, ack_r, flush, ovf_clr,
        input  req_p, req_m, backlog_nz, ovf
    );

    // The requester itself.
    modport slave (
        input  pls_up, pls_dn, ack_r, flush, ovf_clr,
        output req_p, req_m, backlog_nz, ovf
    );
endinterface

// File: rtl/cnt_req_chan.sv
// Purpose: one channel: signed pulse backlog, request FSM and post-acknowledge gap timer.
// Latency: a pulse is in the backlog after 1 edge; an idle channel raises the request on the next edge.
// Backpressure: one request at a time, held until ack_r; the backlog saturates and sets ovf.
module cnt_req_chan
    import cnt_req_pkg::*;
#(
    parameter int ACC_W   = 6,
    parameter int GAP_CYC = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic flush_i,
    input  logic ovf_clr_i,
    input  logic pls_up_i,
    input  logic pls_dn_i,
    input  logic ack_r_i,
    output logic req_p_o,
    output logic req_m_o,
    output logic backlog_nz_o,
    output logic ovf_o
);

    localparam int                       MAX_I    = sat_max(ACC_W);
    localparam logic signed [ACC_W:0]    MAX_P    = MAX_I[ACC_W:0];
    localparam logic signed [ACC_W:0]    MAX_N    = -MAX_P;
    localparam logic signed [ACC_W:0]    ONE      = (ACC_W + 1)'(1);
    localparam logic [GAP_CNT_W-1:0]     GAP_LOAD = GAP_CNT_W'(GAP_CYC - 1);

    chan_st_t                 st_q,  st_d;
    dir_t                     dir_q, dir_d;
    logic [GAP_CNT_W-1:0]     gap_q, gap_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic                     ovf_q, ovf_d;
    logic                     bnz_q, bnz_d;
    logic                     issue;
    logic signed [ACC_W:0]    acc_sum;
    logic                     sat_hi;
    logic                     sat_lo;

    // State register: FSM, backlog and status flags; rst clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q  <= ST_IDLE;
            dir_q <= DIR_P;
            gap_q <= '0;
            acc_q <= '0;
            ovf_q <= 1'b0;
            bnz_q <= 1'b0;
        end else begin
            st_q  <= st_d;
            dir_q <= dir_d;
            gap_q <= gap_d;
            acc_q <= acc_d;
            ovf_q <= ovf_d;
            bnz_q <= bnz_d;
        end
    end

    // Next state: issue from a nonzero backlog, wait for the acknowledge, then sit out the gap.
    always_comb begin
        st_d  = st_q;
        dir_d = dir_q;
        gap_d = gap_q;
        issue = 1'b0;
        case (st_q)
            ST_IDLE: begin
                if (acc_q != '0) begin
                    issue = 1'b1;
                    st_d  = ST_REQ;
                    dir_d = acc_q[ACC_W-1] ? DIR_M : DIR_P;
                end
            end
            ST_REQ: begin
                if (ack_r_i) begin
                    st_d  = ST_GAP;
                    gap_d = GAP_LOAD;
                end
            end
            ST_GAP: begin
                if (gap_q == '0) begin
                    st_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: st_d = ST_IDLE;
        endcase
        if (flush_i) begin
            st_d  = ST_IDLE;
            dir_d = DIR_P;
            gap_d = '0;
            issue = 1'b0;
        end
    end

    // Backlog update: pulses and the issued unit combine in one sum; the result is clamped symmetrically.
    always_comb begin
        acc_sum = {acc_q[ACC_W-1], acc_q};
        if (pls_up_i) acc_sum = acc_sum + ONE;
        if (pls_dn_i) acc_sum = acc_sum - ONE;
        if (issue) acc_sum = (dir_d == DIR_P) ? (acc_sum - ONE) : (acc_sum + ONE);
        sat_hi = (acc_sum > MAX_P);
        sat_lo = (acc_sum < MAX_N);
        if (sat_hi) begin
            acc_d = MAX_P[ACC_W-1:0];
        end else if (sat_lo) begin
            acc_d = MAX_N[ACC_W-1:0];
        end else begin
            acc_d = acc_sum[ACC_W-1:0];
        end
        // A new saturation beats a clear arriving in the same cycle.
        ovf_d = (ovf_q & ~ovf_clr_i) | sat_hi | sat_lo;
        if (flush_i) begin
            acc_d = '0;
            ovf_d = ovf_q & ~ovf_clr_i;
        end
        bnz_d = (acc_d != '0) || (st_d == ST_REQ);
    end

    // Outputs: request levels come straight from the registered state, so they cannot both be high.
    always_comb begin
        req_p_o      = (st_q == ST_REQ) && (dir_q == DIR_P);
        req_m_o      = (st_q == ST_REQ) && (dir_q == DIR_M);
        backlog_nz_o = bnz_q;
        ovf_o        = ovf_q;
    end

endmodule

// File: rtl/cnt_pulse_requester.sv
// Purpose: NCH independent counter-cell increment requesters fed by signed pulse trains.
// Latency: a pulse reaches the backlog in 1 edge; from idle, the request rises 1 edge after that.
// Backpressure: each channel holds its request until ack_r; the backlog saturates with a sticky ovf.
module cnt_pulse_requester
    import cnt_req_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int ACC_W   = 6,
    parameter int GAP_CYC = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    cnt_pulse_requester_if.slave  bus
);

    // Channels are fully independent; flush and ovf_clr fan out to every copy.
    for (genvar i = 0; i < NCH; i++) begin : g_chan
        cnt_req_chan #(
            .ACC_W   (ACC_W),
            .GAP_CYC (GAP_CYC)
        ) u_chan (
            .clk          (clk),
            .rst          (rst),
            .flush_i      (bus.flush),
            .ovf_clr_i    (bus.ovf_clr),
            .pls_up_i     (bus.pls_up[i]),
            .pls_dn_i     (bus.pls_dn[i]),
            .ack_r_i      (bus.ack_r[i]),
            .req_p_o      (bus.req_p[i]),
            .req_m_o      (bus.req_m[i]),
            .backlog_nz_o (bus.backlog_nz[i]),
            .ovf_o        (bus.ovf[i])
        );
    end

endmodule

// File: tb/tb_cnt_pulse_requester.sv
// Purpose: randomized and directed stimulus against a backlog/credit reference model with a scoreboard.
// Latency: expectations are queued per edge and checked 1 time unit after that edge.
// Backpressure: acknowledges are generated by the bench, sometimes withheld for long windows.
module tb_cnt_pulse_requester;

    localparam int NCH     = 4;
    localparam int ACC_W   = 6;
    localparam int GAP_CYC = 1;
    localparam int MAXV    = (1 << (ACC_W - 1)) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cnt_pulse_requester_if #(.NCH(NCH)) bus ();

    cnt_pulse_requester #(
        .NCH     (NCH),
        .ACC_W   (ACC_W),
        .GAP_CYC (GAP_CYC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [NCH-1:0] rp;
        logic [NCH-1:0] rm;
        logic [NCH-1:0] nz;
        logic [NCH-1:0] ov;
    } exp_t;

    typedef struct {
        int edge_no;
        int ch;
        bit plus;
    } ev_t;

    exp_t st_q[$];
    ev_t  ev_q[$];

    int total = 0;
    int bad   = 0;
    int edge_cnt = 0;

    // Reference model: signed backlog, one outstanding credit, earliest edge allowed to issue.
    int bl[NCH];
    bit outst[NCH];
    int dir[NCH];
    int ready_at[NCH];
    bit ov[NCH];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s edge=%0d actual=%0h required=%0h", name, edge_cnt, act, req);
        end
    endtask

    // Drive one cycle of inputs and advance the model to the state expected after the next edge.
    task automatic step(input logic [NCH-1:0] up, input logic [NCH-1:0] dn,
                        input logic [NCH-1:0] ack, input logic fl, input logic r,
                        input logic clr);
        exp_t e;
        int   nb;
        int   e_no;
        bit   iss;
        @(negedge clk);
        bus.pls_up  = up;
        bus.pls_dn  = dn;
        bus.ack_r   = ack;
        bus.flush   = fl;
        bus.ovf_clr = clr;
        rst         = r;
        e_no = edge_cnt + 1;
        for (int ch = 0; ch < NCH; ch++) begin
            if (r) begin
                bl[ch] = 0; outst[ch] = 0; ready_at[ch] = 0; ov[ch] = 0;
            end else if (fl) begin
                bl[ch] = 0; outst[ch] = 0; ready_at[ch] = 0;
                ov[ch] = ov[ch] && !clr;
            end else begin
                iss = 0;
                if (outst[ch]) begin
                    if (ack[ch]) begin
                        outst[ch]    = 0;
                        ready_at[ch] = e_no + GAP_CYC + 1;
                    end
                end else if (e_no >= ready_at[ch] && bl[ch] != 0) begin
                    iss       = 1;
                    dir[ch]   = (bl[ch] > 0) ? 1 : -1;
                    outst[ch] = 1;
                    ev_q.push_back('{e_no, ch, dir[ch] > 0});
                end
                nb = bl[ch] + int'(up[ch]) - int'(dn[ch]) - (iss ? dir[ch] : 0);
                ov[ch] = ov[ch] && !clr;
                if (nb > MAXV)  begin nb = MAXV;  ov[ch] = 1; end
                if (nb < -MAXV) begin nb = -MAXV; ov[ch] = 1; end
                bl[ch] = nb;
            end
            e.rp[ch] = outst[ch] && (dir[ch] > 0);
            e.rm[ch] = outst[ch] && (dir[ch] < 0);
            e.nz[ch] = (bl[ch] != 0) || outst[ch];
            e.ov[ch] = ov[ch];
        end
        st_q.push_back(e);
    endtask

    task automatic idle(input int n, input logic [NCH-1:0] ack);
        for (int k = 0; k < n; k++) step('0, '0, ack, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: compare every edge against the queued expectation and match request rises to issue events.
    initial begin : monitor
        exp_t e;
        ev_t  v;
        logic [NCH-1:0] prev_p;
        logic [NCH-1:0] prev_m;
        prev_p = '0;
        prev_m = '0;
        forever begin
            @(posedge clk);
            edge_cnt++;
            #1;
            if (st_q.size() > 0) begin
                e = st_q.pop_front();
                chk("req_p",      64'(bus.req_p),      64'(e.rp));
                chk("req_m",      64'(bus.req_m),      64'(e.rm));
                chk("backlog_nz", 64'(bus.backlog_nz), 64'(e.nz));
                chk("ovf",        64'(bus.ovf),        64'(e.ov));
                chk("req_excl",   64'(bus.req_p & bus.req_m), 64'(0));
                for (int ch = 0; ch < NCH; ch++) begin
                    if ((bus.req_p[ch] && !prev_p[ch]) || (bus.req_m[ch] && !prev_m[ch])) begin
                        if (ev_q.size() == 0) begin
                            chk("issue_unexpected", 64'(ch), 64'(-1));
                        end else begin
                            v = ev_q.pop_front();
                            chk("issue_ch",   64'(ch),              64'(v.ch));
                            chk("issue_edge", 64'(edge_cnt),        64'(v.edge_no));
                            chk("issue_dir",  64'(bus.req_p[ch]),   64'(v.plus));
                        end
                    end
                end
                prev_p = bus.req_p;
                prev_m = bus.req_m;
            end
        end
    end

    initial begin : stim
        logic [NCH-1:0] up, dn, ack;
        logic           fl, r, clr;
        bus.pls_up = '0; bus.pls_dn = '0; bus.ack_r = '0;
        bus.flush = 1'b0; bus.ovf_clr = 1'b0; rst = 1'b1;
        for (int ch = 0; ch < NCH; ch++) begin
            bl[ch] = 0; outst[ch] = 0; dir[ch] = 1; ready_at[ch] = 0; ov[ch] = 0;
        end
        repeat (3) step('0, '0, '0, 1'b0, 1'b1, 1'b0);

        // Single up pulse on ch0; acknowledge withheld for several cycles.
        step(4'b0001, '0, '0, 1'b0, 1'b0, 1'b0);
        idle(6, '0);
        step('0, '0, 4'b0001, 1'b0, 1'b0, 1'b0);
        idle(3, '0);

        // Burst of three down pulses on ch1, ack two cycles after each request.
        step('0, 4'b0010, '0, 1'b0, 1'b0, 1'b0);
        step('0, 4'b0010, '0, 1'b0, 1'b0, 1'b0);
        step('0, 4'b0010, '0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 12; k++) step('0, '0, (k % 4 == 2) ? 4'b0010 : 4'b0000, 1'b0, 1'b0, 1'b0);

        // Cancelling pulses on ch2, then an up pulse coinciding with an issue.
        step(4'b0100, 4'b0100, '0, 1'b0, 1'b0, 1'b0);
        idle(2, '0);
        step(4'b0100, '0, '0, 1'b0, 1'b0, 1'b0);
        step(4'b0100, '0, '0, 1'b0, 1'b0, 1'b0);
        idle(2, 4'b0100);
        idle(4, 4'b0100);

        // Saturate ch3 with no acknowledge, then clear ovf.
        repeat (40) step(4'b1000, '0, '0, 1'b0, 1'b0, 1'b0);
        idle(2, '0);
        step('0, '0, '0, 1'b0, 1'b0, 1'b1);
        idle(2, '0);
        // Saturating pulse together with ovf_clr: the set wins.
        step(4'b1000, '0, '0, 1'b0, 1'b0, 1'b1);
        idle(1, '0);

        // Direction held while the backlog changes sign during a request on ch1.
        step(4'b0010, '0, '0, 1'b0, 1'b0, 1'b0);
        idle(1, '0);
        repeat (3) step('0, 4'b0010, '0, 1'b0, 1'b0, 1'b0);
        step('0, '0, 4'b0010, 1'b0, 1'b0, 1'b0);
        idle(6, 4'b0010);

        // Flush mid-request with ack, then reset mid-request with ack.
        step(4'b0001, '0, '0, 1'b0, 1'b0, 1'b0);
        idle(2, '0);
        step(4'b0001, 4'b0100, 4'b0001, 1'b1, 1'b0, 1'b0);
        idle(2, '0);
        step(4'b0011, '0, '0, 1'b0, 1'b0, 1'b0);
        idle(2, '0);
        step(4'b0001, '0, 4'b0011, 1'b0, 1'b1, 1'b0);
        idle(3, '0);

        // Randomized traffic with alternating acknowledge-starved windows.
        for (int i = 0; i < 2500; i++) begin
            if (((i / 200) % 3) == 2) begin
                up  = NCH'($urandom) | NCH'($urandom);
                dn  = NCH'($urandom) & NCH'($urandom) & NCH'($urandom);
                ack = '0;
            end else begin
                up  = NCH'($urandom) & NCH'($urandom);
                dn  = NCH'($urandom) & NCH'($urandom);
                ack = NCH'($urandom) & NCH'($urandom);
            end
            fl  = ($urandom_range(0, 199) == 0);
            r   = ($urandom_range(0, 499) == 0);
            clr = ($urandom_range(0, 39) == 0);
            step(up, dn, ack, fl, r, clr);
        end
        idle(10, '1);

        @(posedge clk);
        #2;
        chk("issue_drained", 64'(ev_q.size()), 64'(0));
        chk("exp_drained",   64'(st_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
